// File: rtl/rv_wb_regfile.sv
// Writeback stage: 32x32 register file with x0 hardwired to zero, same-cycle read bypass,
// destination-busy scoreboard, and a small store queue draining over valid/ready.
module rv_wb_regfile #(
  parameter int XLEN     = 32,
  parameter int MQ_DEPTH = 4,
  parameter int MQ_CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_result_valid,
  input  logic [XLEN-1:0]  alu_result_addr,
  input  logic             alu_result_reg_memn,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic             iss_reg_memn,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [31:0]      rd_busy,
  output logic             mem_wr_valid,
  output logic [XLEN-1:0]  mem_wr_addr,
  output logic [XLEN-1:0]  mem_wr_data,
  input  logic             mem_wr_ready,
  output logic             mq_full,
  output logic [MQ_CW-1:0] mq_count,
  output logic             mq_overflow
);

  localparam int PW = $clog2(MQ_DEPTH);

  logic [XLEN-1:0]  regs [32];
  logic [31:0]      busy, busy_next;
  logic [XLEN-1:0]  q_addr [MQ_DEPTH];
  logic [XLEN-1:0]  q_data [MQ_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [MQ_CW-1:0] count;
  logic             ovf;

  logic [4:0] wa;
  logic       reg_we, iss_set, push, pop, push_ok;

  assign wa      = alu_result_addr[4:0];
  assign reg_we  = alu_result_valid && alu_result_reg_memn && (wa != 5'd0);
  assign iss_set = iss_valid && iss_reg_memn && (iss_rd != 5'd0);
  assign push    = alu_result_valid && !alu_result_reg_memn;
  assign pop     = (count != '0) && mem_wr_ready;
  // A push into a full queue still lands when the head drains in the same cycle.
  assign push_ok = push && (!mq_full || pop);

  assign rs1_data = (rs1_addr == 5'd0) ? '0 :
                    (reg_we && wa == rs1_addr) ? alu_result : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 :
                    (reg_we && wa == rs2_addr) ? alu_result : regs[rs2_addr];

  // Set is applied after clear so a re-issue at the writeback edge keeps the bit.
  always_comb begin
    busy_next = busy;
    if (reg_we)  busy_next[wa]     = 1'b0;
    if (iss_set) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the architectural registers must read 0 after reset, so this array is reset;
  // the store-queue payload below is not, because pointers alone define what is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (reg_we) regs[wa] <= alu_result;
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + MQ_CW'(1);
        2'b01:   count <= count - MQ_CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= alu_result_addr;
      q_data[wr_ptr] <= alu_result;
    end
  end

  assign rd_busy      = busy;
  assign mem_wr_valid = (count != '0);
  assign mem_wr_addr  = q_addr[rd_ptr];
  assign mem_wr_data  = q_data[rd_ptr];
  assign mq_full      = (count == MQ_CW'(MQ_DEPTH));
  assign mq_count     = count;
  assign mq_overflow  = ovf;

endmodule

// File: tb/tb_rv_wb_regfile.sv
// Randomized and directed bench for rv_wb_regfile against an array/queue reference model.
module tb_rv_wb_regfile;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] alu_result, alu_result_addr;
  logic            alu_result_valid, alu_result_reg_memn;
  logic            iss_valid, iss_reg_memn;
  logic [4:0]      iss_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [31:0]     rd_busy;
  logic            mem_wr_valid, mem_wr_ready, mq_full, mq_overflow;
  logic [XLEN-1:0] mem_wr_addr, mem_wr_data;
  logic [CW-1:0]   mq_count;

  rv_wb_regfile #(.XLEN(XLEN), .MQ_DEPTH(DEPTH), .MQ_CW(CW)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .alu_result_addr(alu_result_addr), .alu_result_reg_memn(alu_result_reg_memn),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_reg_memn(iss_reg_memn),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_busy(rd_busy), .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready), .mq_full(mq_full),
    .mq_count(mq_count), .mq_overflow(mq_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  ent_t        m_q [$];
  bit          m_ovf;
  int          n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] exp_rs(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (alu_result_valid && alu_result_reg_memn && alu_result_addr[4:0] == a) return alu_result;
    return m_reg[a];
  endfunction

  task automatic check_all();
    check("rs1", rs1_data, exp_rs(rs1_addr));
    check("rs2", rs2_data, exp_rs(rs2_addr));
    check("busy", rd_busy, m_busy);
    check("valid", {31'd0, mem_wr_valid}, {31'd0, m_q.size() != 0});
    check("count", {29'd0, mq_count}, 32'(m_q.size()));
    check("full", {31'd0, mq_full}, {31'd0, m_q.size() == DEPTH});
    check("ovf", {31'd0, mq_overflow}, {31'd0, m_ovf});
    if (m_q.size() != 0) begin
      check("head_a", mem_wr_addr, m_q[0].a);
      check("head_d", mem_wr_data, m_q[0].d);
    end
  endtask

  // Applies the edge's effect to the model using the rules of the writeback stage.
  task automatic m_edge();
    bit wr, pop, push;
    int sz;
    wr   = alu_result_valid && alu_result_reg_memn && alu_result_addr[4:0] != 5'd0;
    push = alu_result_valid && !alu_result_reg_memn;
    sz   = m_q.size();
    pop  = sz != 0 && mem_wr_ready;
    if (wr) begin
      m_reg[alu_result_addr[4:0]] = alu_result;
      m_busy[alu_result_addr[4:0]] = 1'b0;
    end
    if (iss_valid && iss_reg_memn && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back('{a: alu_result_addr, d: alu_result});
      else m_ovf = 1'b1;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    if (reset) m_edge(); else m_clear();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_result = '0; alu_result_valid = 0; alu_result_addr = '0; alu_result_reg_memn = 0;
    iss_valid = 0; iss_rd = '0; iss_reg_memn = 0;
    rs1_addr = '0; rs2_addr = '0; mem_wr_ready = 0;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    alu_result_valid = 1; alu_result_reg_memn = 1; alu_result_addr = {27'd0, a}; alu_result = d;
  endtask

  task automatic st_push(input logic [31:0] a, input logic [31:0] d);
    alu_result_valid = 1; alu_result_reg_memn = 0; alu_result_addr = a; alu_result = d;
  endtask

  task automatic pulse_reset();
    idle();
    #2 reset = 0;
    #1;
    check("arst_valid", {31'd0, mem_wr_valid}, 32'd0);
    check("arst_count", {29'd0, mq_count}, 32'd0);
    m_clear();
    @(negedge clk);
    cycle();
    reset = 1;
  endtask

  initial begin
    m_clear();
    idle();
    reset = 0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1;

    // x5 write with same-cycle bypass
    reg_wr(5'd5, 32'h0000_1234); rs1_addr = 5'd5;
    #1 check("x5_bypass", rs1_data, 32'h0000_1234);
    cycle();
    idle(); rs1_addr = 5'd5;
    #1 check("x5_read", rs1_data, 32'h0000_1234);
    cycle();

    // x0 write discarded
    reg_wr(5'd0, 32'hFFFF_FFFF); rs1_addr = 5'd0;
    cycle();
    idle();
    #1 check("x0_read", rs1_data, 32'd0);
    check("x0_busy", rd_busy, 32'd0);
    cycle();

    // busy window for x7, then re-issue at writeback edge
    iss_valid = 1; iss_reg_memn = 1; iss_rd = 5'd7;
    cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      #1 check("busy7_wait", {31'd0, rd_busy[7]}, 32'd1);
      cycle();
    end
    reg_wr(5'd7, 32'hA5A5_0007);
    #1 check("busy7_wb", {31'd0, rd_busy[7]}, 32'd1);
    cycle();
    idle();
    #1 check("busy7_clr", {31'd0, rd_busy[7]}, 32'd0);
    iss_valid = 1; iss_reg_memn = 1; iss_rd = 5'd7;
    cycle();
    idle();
    reg_wr(5'd7, 32'h0000_0077); iss_valid = 1; iss_reg_memn = 1; iss_rd = 5'd7;
    cycle();
    idle();
    #1 check("busy7_set_wins", {31'd0, rd_busy[7]}, 32'd1);
    cycle();

    // fill the store queue, overflow, then drain in order
    for (int i = 0; i < 4; i++) begin
      st_push(32'h100 + 32'(4 * i), 32'(i + 1));
      cycle();
    end
    idle();
    #1 check("q_full", {31'd0, mq_full}, 32'd1);
    check("q_count4", {29'd0, mq_count}, 32'd4);
    check("q_head_a", mem_wr_addr, 32'h100);
    st_push(32'h200, 32'h99);
    cycle();
    idle();
    #1 check("q_ovf", {31'd0, mq_overflow}, 32'd1);
    check("q_head_held", mem_wr_data, 32'd1);
    mem_wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("drain_a", mem_wr_addr, 32'h100 + 32'(4 * i));
      check("drain_d", mem_wr_data, 32'(i + 1));
      cycle();
    end
    #1 check("drain_empty", {31'd0, mem_wr_valid}, 32'd0);
    cycle();

    // push and pop while full
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      st_push(32'h300 + 32'(4 * i), 32'(16 + i));
      cycle();
    end
    st_push(32'h400, 32'hBEEF); mem_wr_ready = 1;
    cycle();
    idle();
    #1 check("pp_count", {29'd0, mq_count}, 32'd4);
    check("pp_ovf", {31'd0, mq_overflow}, 32'd0);
    mem_wr_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    idle();
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      alu_result_valid    = ($urandom_range(0, 3) != 0);
      alu_result_reg_memn = $urandom_range(0, 1);
      alu_result_addr     = $urandom;
      alu_result          = $urandom;
      iss_valid           = $urandom_range(0, 1);
      iss_reg_memn        = $urandom_range(0, 1);
      iss_rd              = 5'($urandom);
      rs1_addr            = ($urandom_range(0, 2) == 0) ? alu_result_addr[4:0] : 5'($urandom);
      rs2_addr            = 5'($urandom);
      mem_wr_ready        = ($urandom_range(0, 2) != 0);
      if (n % 10 == 0) rs1_addr = 5'd0;
      cycle();
    end

    // asynchronous reset with two queued stores
    pulse_reset();
    st_push(32'h500, 32'h1); cycle();
    st_push(32'h504, 32'h2); cycle();
    idle();
    #1 check("pre_rst_count", {29'd0, mq_count}, 32'd2);
    pulse_reset();
    mem_wr_ready = 1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1 check("post_rst_rs1", rs1_data, 32'd0);
      cycle();
    end
    #1 check("post_rst_valid", {31'd0, mem_wr_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
